svm_stage_sequencer: RTL and testbench
======================================

Name: svm_stage_sequencer

Overview:
Top-level controller for one cascaded-SVM stage. It streams the test vector's pixels from pixel RAM into the kernel array, waits for the kernel pipeline to drain, and steps the decision-function unit through every support vector. It then captures the class result and reports completion with a start/busy/done handshake. It replaces the free-running memory control of the stage top, so that stages can be chained and restarted.

Parameters:
XLEN_PIXEL, 8, pixel width in bits
NUM_OF_PIXELS, 784, pixels per test vector
NUM_OF_SV, 10, support vectors in this stage
KERNEL_LAT, 3, cycles from the last kernel_en to a valid kernel output
PIX_AW, $clog2(NUM_OF_PIXELS), pixel address width
SV_AW, $clog2(NUM_OF_SV), support-vector index width

Ports:
clk  in  1  clock, all state on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a classification; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse when y_class is valid
pix_re  out  1  pixel RAM read request
pix_addr  out  PIX_AW  pixel RAM address
pix_ready  in  1  RAM accepts the request this cycle
pix_valid  in  1  RAM returns pixel data this cycle, in order
stall_MEM  out  1  kernel hold; high in FETCH when pix_valid=0
kernel_clr  out  1  one-cycle accumulator clear to the kernels
kernel_en  out  1  kernels consume x_test this cycle; equals pix_valid in FETCH
decision_funct_en  out  1  decision unit consumes the term at sv_idx
sv_idx  out  SV_AW  support-vector index presented to the decision unit
dec_valid  in  1  decision unit result valid
y_class_in  in  1  class from the decision unit
y_class  out  1  registered class, held until the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, pix_re, stall_MEM, kernel_clr, kernel_en, decision_funct_en, y_class all 0. pix_addr=0, sv_idx=0, all counters 0.
- States: IDLE, FETCH, DRAIN, DECIDE, WAIT_DEC, DONE.
- IDLE: start=1 -> FETCH. Same edge: kernel_clr pulses for 1 cycle, counters cleared, y_class cleared. start in any other state is ignored.
- FETCH, issue side: pix_re=1 while issued<NUM_OF_PIXELS. A request is accepted on pix_re&pix_ready; on acceptance pix_addr and issued increment. pix_addr saturates at NUM_OF_PIXELS-1 and never wraps.
- FETCH, return side: kernel_en=pix_valid; stall_MEM=~pix_valid; returned increments on each pix_valid.
- FETCH exit: when returned reaches NUM_OF_PIXELS -> DRAIN. pix_valid outside FETCH is ignored.
- DRAIN: counts KERNEL_LAT cycles with stall_MEM=1, then -> DECIDE.
- DECIDE: decision_funct_en=1 for exactly NUM_OF_SV consecutive cycles, with sv_idx=0..NUM_OF_SV-1, one per cycle. Then -> WAIT_DEC with sv_idx held at NUM_OF_SV-1.
- WAIT_DEC: on dec_valid=1, latch y_class<=y_class_in and go to DONE.
- DONE: done=1 for one cycle, busy drops the same cycle, then -> IDLE.
- Zero-stall latency, measured from start sampled (cycle 0): FETCH spans NUM_OF_PIXELS+RAM latency; DRAIN spans KERNEL_LAT; DECIDE spans NUM_OF_SV.
- abort=1: next state IDLE. Strobes drop, busy=0, no done pulse, y_class unchanged. abort takes priority over every other transition, including start in IDLE.
- Simultaneous pix_valid and state exit: the last pixel's kernel_en is still issued.
- Reset mid-operation: all state is lost, and a new start is required.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds output cycle_count[31:0]. The counter clears on an accepted start and increments every cycle while busy=1. It freezes at DONE and saturates at 2^32-1. abort holds its value.
- Undefined: the port and logic are absent.

Decomposition:
- Shared package svm_pkg: state encoding (6 states), XLEN_PIXEL, NUM_OF_PIXELS, NUM_OF_SV defaults.
- One natural sub-module, svm_pix_fetch: the issue/return counters and pix_addr generation. The FSM instantiates it with start/clear and receives a fetch_done flag.

Test Plan:
Bench parameters for all scenarios: NUM_OF_PIXELS=4, NUM_OF_SV=3, KERNEL_LAT=2.
1. Zero-stall run: RAM with 1-cycle latency, pix_ready=1, start at cycle 0, dec_valid 1 cycle after the last decision_funct_en, y_class_in=1. Required: pix_addr 0,1,2,3; kernel_en 4 cycles; DRAIN 2 cycles; sv_idx 0,1,2; done pulses once; y_class=1.
2. Backpressure: pix_ready toggles 1,0,1,0. Required: pix_addr advances only on ready, exactly 4 kernel_en, stall_MEM=1 on every gap.
3. Abort mid-DECIDE at sv_idx=1. Required: next cycle IDLE, busy=0, no done, y_class keeps its prior value. A subsequent start completes normally.
4. start held high through a whole run. Required: ignored while busy; a second run starts on the cycle after DONE returns to IDLE.
5. Asynchronous reset asserted in FETCH between clock edges. Required: outputs zero immediately; after release, idle until start.
6. SEQ_PERF_CNT_EN defined, scenario 1 repeated. Required: cycle_count equals busy-high cycles (4+1+2+3+1 plus state overhead) and is stable after done.

Source files
------------

// File: rtl/svm_pkg.sv
// ---------------------------------------------------------------------------
// svm_pkg
// Shared definitions for the cascaded-SVM stage control path:
//   - seq_state_t : encoding of the six stage-sequencer states
//   - DEF_*       : default geometry of one stage (pixel width, pixels per
//                   test vector, support vectors, kernel pipeline latency)
// ---------------------------------------------------------------------------
package svm_pkg;

  localparam int DEF_XLEN_PIXEL    = 8;
  localparam int DEF_NUM_OF_PIXELS = 784;
  localparam int DEF_NUM_OF_SV     = 10;
  localparam int DEF_KERNEL_LAT    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DECIDE   = 3'd3,
    ST_WAIT_DEC = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/svm_pix_fetch.sv
// ---------------------------------------------------------------------------
// svm_pix_fetch
// Pixel RAM request/return bookkeeping for one test vector.
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : zero all counters and the address (accepted start)
//   active       : sequencer is in its fetch phase
//   pix_ready    : RAM accepts the current request
//   pix_valid    : RAM returns one pixel this cycle (in order)
//   pix_re       : read request, held while pixels remain to be issued
//   pix_addr     : address of the next request, saturating at the last pixel
//   fetch_done   : the final pixel is being returned this cycle
// ---------------------------------------------------------------------------
module svm_pix_fetch
  import svm_pkg::*;
#(
  parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter int PIX_AW        = $clog2(NUM_OF_PIXELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              active,
  input  logic              pix_ready,
  input  logic              pix_valid,
  output logic              pix_re,
  output logic [PIX_AW-1:0] pix_addr,
  output logic              fetch_done
);

  // One extra bit so the counters can represent the full pixel count.
  localparam int                CW        = PIX_AW + 1;
  localparam logic [CW-1:0]     N_TOTAL   = CW'(NUM_OF_PIXELS);
  localparam logic [CW-1:0]     N_LAST    = CW'(NUM_OF_PIXELS - 1);
  localparam logic [PIX_AW-1:0] ADDR_LAST = PIX_AW'(NUM_OF_PIXELS - 1);

  logic [CW-1:0] issued_reg;
  logic [CW-1:0] returned_reg;
  logic          accept;

  assign pix_re     = active && (issued_reg < N_TOTAL);
  assign accept     = pix_re && pix_ready;
  // Combinational so the sequencer leaves fetch on the same edge that
  // consumes the last pixel; that pixel's kernel_en is therefore not lost.
  assign fetch_done = active && pix_valid && (returned_reg == N_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_reg   <= '0;
      returned_reg <= '0;
      pix_addr     <= '0;
    end else if (clear) begin
      issued_reg   <= '0;
      returned_reg <= '0;
      pix_addr     <= '0;
    end else begin
      if (accept) begin
        issued_reg <= issued_reg + 1'b1;
        if (pix_addr != ADDR_LAST) begin
          pix_addr <= pix_addr + 1'b1;
        end
      end
      if (active && pix_valid) begin
        returned_reg <= returned_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/svm_stage_sequencer.sv
// ---------------------------------------------------------------------------
// svm_stage_sequencer
// Controller for one cascaded-SVM stage: streams the test vector from pixel
// RAM into the kernel array, lets the kernel pipeline drain, steps the
// decision unit through every support vector, then captures the class.
//   clk, rst            : clock, asynchronous active-low reset
//   start / abort       : begin a classification / return to IDLE at once
//   busy / done         : run in progress / one-cycle result-valid pulse
//   pix_re, pix_addr    : pixel RAM request and address
//   pix_ready/pix_valid : RAM request accept / in-order data return
//   stall_MEM           : kernel hold (fetch gaps and the drain window)
//   kernel_clr          : one-cycle accumulator clear at run start
//   kernel_en           : kernels consume the returned pixel
//   decision_funct_en   : decision unit consumes the term at sv_idx
//   dec_valid,y_class_in: decision unit result
//   y_class             : registered class, held until the next start
// Build option: define SEQ_PERF_CNT_EN to add cycle_count[31:0], the number
// of busy cycles in the latest run (saturating).
// ---------------------------------------------------------------------------
module svm_stage_sequencer
  import svm_pkg::*;
#(
  parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
  parameter int KERNEL_LAT    = DEF_KERNEL_LAT,
  parameter int PIX_AW        = $clog2(NUM_OF_PIXELS),
  parameter int SV_AW         = $clog2(NUM_OF_SV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pix_re,
  output logic [PIX_AW-1:0] pix_addr,
  input  logic              pix_ready,
  input  logic              pix_valid,
  output logic              stall_MEM,
  output logic              kernel_clr,
  output logic              kernel_en,
  output logic              decision_funct_en,
  output logic [SV_AW-1:0]  sv_idx,
  input  logic              dec_valid,
  input  logic              y_class_in,
  output logic              y_class
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int               DW         = (KERNEL_LAT > 1) ? $clog2(KERNEL_LAT) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(KERNEL_LAT - 1);
  localparam logic [SV_AW-1:0] SV_LAST    = SV_AW'(NUM_OF_SV - 1);

  seq_state_t    state_reg;
  logic [DW-1:0] drain_cnt_reg;
  logic          fetch_active;
  logic          start_accept;
  logic          fetch_done;

  assign fetch_active = (state_reg == ST_FETCH);
  // abort outranks start even in IDLE
  assign start_accept = (state_reg == ST_IDLE) && start && !abort;

  // The kernel strobes follow the RAM return path directly so each returned
  // pixel is consumed in the cycle it arrives.
  assign kernel_en = fetch_active && pix_valid;
  assign stall_MEM = (fetch_active && !pix_valid) || (state_reg == ST_DRAIN);

  svm_pix_fetch #(
    .NUM_OF_PIXELS (NUM_OF_PIXELS),
    .PIX_AW        (PIX_AW)
  ) u_pix_fetch (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_accept),
    .active     (fetch_active),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_re     (pix_re),
    .pix_addr   (pix_addr),
    .fetch_done (fetch_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      kernel_clr        <= 1'b0;
      decision_funct_en <= 1'b0;
      sv_idx            <= '0;
      drain_cnt_reg     <= '0;
      y_class           <= 1'b0;
    end else begin
      kernel_clr <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state_reg         <= ST_IDLE;
        busy              <= 1'b0;
        decision_funct_en <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              state_reg     <= ST_FETCH;
              busy          <= 1'b1;
              kernel_clr    <= 1'b1;
              y_class       <= 1'b0;
              sv_idx        <= '0;
              drain_cnt_reg <= '0;
            end
          end
          ST_FETCH: begin
            if (fetch_done) begin
              state_reg     <= ST_DRAIN;
              drain_cnt_reg <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_reg == DRAIN_LAST) begin
              state_reg         <= ST_DECIDE;
              decision_funct_en <= 1'b1;
              sv_idx            <= '0;
            end else begin
              drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
          end
          ST_DECIDE: begin
            // sv_idx is left on the last term while waiting for the result
            if (sv_idx == SV_LAST) begin
              state_reg         <= ST_WAIT_DEC;
              decision_funct_en <= 1'b0;
            end else begin
              sv_idx <= sv_idx + 1'b1;
            end
          end
          ST_WAIT_DEC: begin
            if (dec_valid) begin
              state_reg <= ST_DONE;
              y_class   <= y_class_in;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Counts busy cycles; busy is already low in DONE, so the count freezes
  // there without a separate condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (start_accept) begin
      cycle_count <= '0;
    end else if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_svm_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_svm_stage_sequencer
// Each run's expected waveform is built up front as a timeline: the cycle at
// which every pixel request is accepted (from the ready pattern), the cycle
// each pixel returns (in order, per-request latency), and from the last
// return the drain, decide, wait and done windows. Outputs are then checked
// cycle by cycle against that timeline. Cycle 0 of a run is the cycle in
// which start is presented to an idle sequencer.
// ---------------------------------------------------------------------------
module tb_svm_stage_sequencer;

  localparam int NPIX = 4;
  localparam int NSV  = 3;
  localparam int KLAT = 2;
  localparam int PAW  = $clog2(NPIX);
  localparam int SAW  = $clog2(NSV);
  localparam int MAXC = 256;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic start      = 1'b0;
  logic abort      = 1'b0;
  logic pix_ready  = 1'b0;
  logic pix_valid  = 1'b0;
  logic dec_valid  = 1'b0;
  logic y_class_in = 1'b0;
  logic busy, done, pix_re, stall_MEM, kernel_clr, kernel_en;
  logic decision_funct_en, y_class;
  logic [PAW-1:0] pix_addr;
  logic [SAW-1:0] sv_idx;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rdy    [MAXC];
  int   lat    [NPIX];
  int   acc_at [NPIX];
  int   ret_at [NPIX];
  int   dec_delay;
  bit   y_bit;
  bit   hold;
  logic prev_y;

  always #5 clk = ~clk;

  svm_stage_sequencer #(
    .NUM_OF_PIXELS (NPIX),
    .NUM_OF_SV     (NSV),
    .KERNEL_LAT    (KLAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .pix_re            (pix_re),
    .pix_addr          (pix_addr),
    .pix_ready         (pix_ready),
    .pix_valid         (pix_valid),
    .stall_MEM         (stall_MEM),
    .kernel_clr        (kernel_clr),
    .kernel_en         (kernel_en),
    .decision_funct_en (decision_funct_en),
    .sv_idx            (sv_idx),
    .dec_valid         (dec_valid),
    .y_class_in        (y_class_in),
    .y_class           (y_class)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_count       (cycle_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic string tg(input string name, input string sig, input int c);
    return $sformatf("%s.%s@%0d", name, sig, c);
  endfunction

  function automatic bit is_ret(input int c);
    for (int i = 0; i < NPIX; i++) begin
      if (ret_at[i] == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int acc_before(input int c);
    int n = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (acc_at[i] < c) n++;
    end
    return n;
  endfunction

  // mode 0: always ready, 1: ready on odd cycles only, 2: random (~70%)
  task automatic set_ready(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = (c % 2 == 1);
        default: rdy[c] = (c >= 60) || ($urandom_range(0, 9) < 7);
      endcase
    end
  endtask

  task automatic set_lat(input bit rnd);
    for (int i = 0; i < NPIX; i++) lat[i] = rnd ? int'($urandom_range(1, 3)) : 1;
  endtask

  task automatic check_idle_outputs(input string name, input int c);
    check_eq(tg(name, "busy", c),  32'(busy), 0);
    check_eq(tg(name, "done", c),  32'(done), 0);
    check_eq(tg(name, "pix_re", c), 32'(pix_re), 0);
    check_eq(tg(name, "kernel_en", c), 32'(kernel_en), 0);
    check_eq(tg(name, "stall_MEM", c), 32'(stall_MEM), 0);
    check_eq(tg(name, "kernel_clr", c), 32'(kernel_clr), 0);
    check_eq(tg(name, "dec_en", c), 32'(decision_funct_en), 0);
  endtask

  // Idle cycles with start low and noise on every other input.
  task automatic idle_cycles(input int n, input string name, input bit zero_idx);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start      = 1'b0;
      abort      = 1'($urandom_range(0, 1));
      pix_ready  = 1'($urandom_range(0, 1));
      pix_valid  = 1'($urandom_range(0, 1));
      dec_valid  = 1'($urandom_range(0, 1));
      y_class_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle_outputs(name, k);
      check_eq(tg(name, "y_class", k), 32'(y_class), 32'(prev_y));
      if (zero_idx) begin
        check_eq(tg(name, "pix_addr", k), 32'(pix_addr), 0);
        check_eq(tg(name, "sv_idx", k), 32'(sv_idx), 0);
      end
    end
  endtask

  // mode 0: complete run, 1: abort at sv_idx=1, 2: maybe abort at random,
  // 3: asynchronous reset between edges during fetch
  task automatic run_txn(input string name, input int mode);
    int   c, F, W, D, X, last, end_c;
    bit   alive, in_fetch, in_drain, in_dec;
    logic ex_y;
    c = 1;
    for (int i = 0; i < NPIX; i++) begin
      while (!rdy[c]) c++;
      acc_at[i] = c;
      c++;
    end
    for (int i = 0; i < NPIX; i++) begin
      ret_at[i] = acc_at[i] + lat[i];
      if (i > 0 && ret_at[i] <= ret_at[i-1]) ret_at[i] = ret_at[i-1] + 1;
    end
    F = ret_at[NPIX-1];
    W = F + KLAT + NSV + 1;
    D = W + dec_delay + 1;
    X = -1;
    if (mode == 1) X = F + KLAT + 2;
    if (mode == 2 && $urandom_range(0, 3) == 0) X = int'($urandom_range(1, D - 1));
    last  = (X >= 0) ? X : D - 1;
    end_c = (mode == 3) ? 3 : ((X >= 0) ? X + 3 : D);

    for (c = 0; c <= end_c; c++) begin
      alive = (X < 0) || (c <= X);
      @(posedge clk); #1;
      start      = (c == 0) || hold;
      abort      = (c == X);
      pix_ready  = rdy[c];
      pix_valid  = alive && is_ret(c);
      dec_valid  = (c == W + dec_delay) || (c < W && $urandom_range(0, 3) == 0);
      y_class_in = (c == W + dec_delay) ? y_bit : 1'($urandom_range(0, 1));
      @(negedge clk);
      in_fetch = alive && c >= 1 && c <= F;
      in_drain = alive && c > F && c <= F + KLAT;
      in_dec   = alive && c > F + KLAT && c <= F + KLAT + NSV;
      if (c == 0) ex_y = prev_y;
      else if (alive && c >= D) ex_y = y_bit;
      else ex_y = 1'b0;
      check_eq(tg(name, "busy", c), 32'(busy), 32'(alive && c >= 1 && c < D));
      check_eq(tg(name, "done", c), 32'(done), 32'(alive && c == D));
      check_eq(tg(name, "kernel_clr", c), 32'(kernel_clr), 32'(alive && c == 1));
      check_eq(tg(name, "pix_re", c), 32'(pix_re), 32'(in_fetch && acc_before(c) < NPIX));
      check_eq(tg(name, "kernel_en", c), 32'(kernel_en), 32'(in_fetch && is_ret(c)));
      check_eq(tg(name, "stall_MEM", c), 32'(stall_MEM), 32'((in_fetch && !is_ret(c)) || in_drain));
      check_eq(tg(name, "dec_en", c), 32'(decision_funct_en), 32'(in_dec));
      check_eq(tg(name, "y_class", c), 32'(y_class), 32'(ex_y));
      if (in_fetch) begin
        check_eq(tg(name, "pix_addr", c), 32'(pix_addr),
                 (acc_before(c) < NPIX - 1) ? acc_before(c) : NPIX - 1);
      end
      if (alive && c > F + KLAT && c <= D) begin
        check_eq(tg(name, "sv_idx", c), 32'(sv_idx),
                 (c - (F + KLAT + 1) < NSV - 1) ? c - (F + KLAT + 1) : NSV - 1);
      end
`ifdef SEQ_PERF_CNT_EN
      if (c >= 1) begin
        check_eq(tg(name, "cycle_count", c), cycle_count, (c - 1 < last) ? c - 1 : last);
      end
`endif
    end

    if (mode == 3) begin
      #2 rst = 1'b0;
      #1;
      check_idle_outputs({name, "_rst"}, c);
      check_eq(tg(name, "rst_pix_addr", c), 32'(pix_addr), 0);
      check_eq(tg(name, "rst_sv_idx", c), 32'(sv_idx), 0);
      check_eq(tg(name, "rst_y_class", c), 32'(y_class), 0);
`ifdef SEQ_PERF_CNT_EN
      check_eq(tg(name, "rst_cycle_count", c), cycle_count, 0);
`endif
      start = 1'b0; abort = 1'b0; pix_valid = 1'b0; dec_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      prev_y = 1'b0;
    end else begin
      prev_y = (X >= 0) ? 1'b0 : y_bit;
    end
    $display("txn %-14s fetch_end=%0d done_at=%0d abort_at=%0d y=%0b", name, F, D, X, prev_y);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_y = 1'b0;
    hold   = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_idle_outputs("reset", 0);
    check_eq("reset.pix_addr", 32'(pix_addr), 0);
    check_eq("reset.sv_idx", 32'(sv_idx), 0);
    check_eq("reset.y_class", 32'(y_class), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(2, "post_reset", 1'b1);

    // zero-stall reference run
    set_ready(0); set_lat(1'b0); dec_delay = 0; y_bit = 1'b1;
    run_txn("zero_stall", 0);
    idle_cycles(2, "gap1", 1'b0);

    // alternating ready
    set_ready(1); set_lat(1'b0); dec_delay = 1; y_bit = 1'b0;
    run_txn("backpressure", 0);
    idle_cycles(1, "gap2", 1'b0);

    // abort while presenting sv_idx=1, then a clean run
    set_ready(0); set_lat(1'b1); dec_delay = 0; y_bit = 1'b1;
    run_txn("abort_sv1", 1);
    idle_cycles(2, "gap3", 1'b0);
    set_ready(2); set_lat(1'b1); dec_delay = 2; y_bit = 1'b1;
    run_txn("after_abort", 0);

    // start held high across two back-to-back runs
    hold = 1'b1;
    set_ready(0); set_lat(1'b0); dec_delay = 0; y_bit = 1'b0;
    run_txn("hold_a", 0);
    set_ready(2); set_lat(1'b1); dec_delay = 1; y_bit = 1'b1;
    run_txn("hold_b", 0);
    hold = 1'b0;
    idle_cycles(2, "gap4", 1'b0);

    // asynchronous reset mid-fetch
    set_ready(0); set_lat(1'b1); dec_delay = 0; y_bit = 1'b1;
    run_txn("reset_fetch", 3);
    idle_cycles(3, "post_async", 1'b1);

    // randomized runs, some aborted
    for (int r = 0; r < 12; r++) begin
      set_ready(2); set_lat(1'b1);
      dec_delay = int'($urandom_range(0, 3));
      y_bit     = 1'($urandom_range(0, 1));
      run_txn($sformatf("random_%0d", r), 2);
      idle_cycles(int'($urandom_range(0, 2)), $sformatf("gap_r%0d", r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
